multiplicador_sequencial: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier for the ULA. It reuses one instance of the existing 8-bit ripple adder (`somador`) across eight iterations instead of building an array multiplier. A start/done handshake sequences the adder. It sits beside the adder in the ULA and gives the ULA a 16-bit multiply result.

---
 rtl/multiplicador_sequencial.sv | 119 +++++++++++
 tb/tb_multiplicador_sequencial.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/multiplicador_sequencial.sv
// Sequential 8x8 unsigned shift-and-add multiplier reusing one 8-bit ripple adder.
// Start is sampled in OCIOSO; fim pulses 9 cycles later; iniciar is ignored while busy.

module somador (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_s,
  output logic       o_cout
);
  logic [8:0] w_c;

  assign w_c[0] = i_cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_fa
      assign o_s[gi]     = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_cout = w_c[8];
endmodule

module multiplicador_sequencial (
  input  logic        clk,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        pronto,
  output logic        ocupado,
  output logic        fim,
  output logic [15:0] produto
);
  typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

  estado_t     r_estado;
  estado_t     w_prox;
  logic [7:0]  r_ra;
  logic [7:0]  r_acc;
  logic [7:0]  r_rq;
  logic [2:0]  r_cnt;
  logic [15:0] r_produto;

  logic [7:0]  w_parcela;
  logic [7:0]  w_s;
  logic        w_cout;
  logic [15:0] w_desloc;

  assign w_parcela = r_rq[0] ? r_ra : 8'h00;

  somador u_somador (
    .i_a    (r_acc),
    .i_b    (w_parcela),
    .i_cin  (1'b0),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // The adder carry lands in bit 15; the bit shifted out of rq is dropped.
  assign w_desloc = {w_cout, w_s, r_rq[7:1]};

  always_comb begin
    w_prox  = r_estado;
    pronto  = 1'b0;
    ocupado = 1'b0;
    fim     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        pronto = 1'b1;
        if (iniciar) w_prox = CALC;
      end
      CALC: begin
        ocupado = 1'b1;
        if (r_cnt == 3'd7) w_prox = FIM;
      end
      FIM: begin
        fim    = 1'b1;
        w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_ra      <= 8'h00;
      r_acc     <= 8'h00;
      r_rq      <= 8'h00;
      r_cnt     <= 3'd0;
      r_produto <= 16'h0000;
    end else begin
      r_estado <= w_prox;
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_ra      <= a;
            r_rq      <= b;
            r_acc     <= 8'h00;
            r_cnt     <= 3'd0;
            r_produto <= 16'h0000;
          end
        end
        CALC: begin
          {r_acc, r_rq} <= w_desloc;
          r_cnt         <= r_cnt + 3'd1;
          // Result is registered on the last iteration so it is valid throughout FIM.
          if (r_cnt == 3'd7) r_produto <= w_desloc;
        end
        default: ;
      endcase
    end
  end

  assign produto = r_produto;
endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed self-checking bench for multiplicador_sequencial; inputs driven and outputs sampled on negedge.
module tb_multiplicador_sequencial;
  logic        clk;
  logic        reset;
  logic        iniciar;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        pronto;
  logic        ocupado;
  logic        fim;
  logic [15:0] produto;

  int total = 0;
  int bad   = 0;

  multiplicador_sequencial dut (
    .clk     (clk),
    .reset   (reset),
    .iniciar (iniciar),
    .a       (a),
    .b       (b),
    .pronto  (pronto),
    .ocupado (ocupado),
    .fim     (fim),
    .produto (produto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the following idle cycle.
  task automatic mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e, input string tag);
    a = x; b = y; iniciar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    check_eq({tag, "_clr"}, produto, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      check_eq({tag, "_ocup"}, {15'd0, ocupado}, 16'd1);
      check_eq({tag, "_nofim"}, {15'd0, fim}, 16'd0);
      if (i < 8) @(negedge clk);
    end
    @(negedge clk);
    check_eq({tag, "_fim"}, {15'd0, fim}, 16'd1);
    check_eq({tag, "_prod"}, produto, e);
    @(negedge clk);
    check_eq({tag, "_pronto"}, {15'd0, pronto}, 16'd1);
    check_eq({tag, "_fim0"}, {15'd0, fim}, 16'd0);
    check_eq({tag, "_hold"}, produto, e);
  endtask

  initial begin
    int nfim;
    reset = 1'b0; iniciar = 1'b1; a = 8'hFF; b = 8'hFF;
    #1 reset = 1'b1;
    #1;
    check_eq("rst_pronto", {15'd0, pronto}, 16'd1);
    repeat (3) @(negedge clk);
    check_eq("rst_pronto2", {15'd0, pronto}, 16'd1);
    check_eq("rst_ocupado", {15'd0, ocupado}, 16'd0);
    check_eq("rst_fim", {15'd0, fim}, 16'd0);
    check_eq("rst_produto", produto, 16'h0000);
    reset = 1'b0;
    mul(8'hFF, 8'hFF, 16'hFE01, "max");

    mul(8'd13, 8'd11, 16'd143, "basic");
    mul(8'd0, 8'd200, 16'd0, "zero_a");
    mul(8'd200, 8'd0, 16'd0, "zero_b");
    mul(8'd1, 8'd255, 16'd255, "one");
    mul(8'd128, 8'd2, 16'd256, "pow2");
    mul(8'hFF, 8'hFF, 16'hFE01, "max2");

    // Start while busy: second request lands in CALC cycle 4 and must be ignored.
    a = 8'd7; b = 8'd6; iniciar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) begin a = 8'd9; b = 8'd9; iniciar = 1'b1; end
      if (c == 5) iniciar = 1'b0;
      check_eq("busy_ocup", {15'd0, ocupado}, 16'd1);
      if (c < 8) @(negedge clk);
    end
    @(negedge clk);
    check_eq("busy_fim", {15'd0, fim}, 16'd1);
    check_eq("busy_prod", produto, 16'd42);
    nfim = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fim || ocupado) nfim++;
    end
    check_eq("busy_noqueue", nfim[15:0], 16'd0);
    check_eq("busy_hold", produto, 16'd42);

    // Continuous start: a result every 10 cycles, cleared on each accept.
    a = 8'd3; b = 8'd5; iniciar = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("cont_clr", produto, 16'h0000);
      check_eq("cont_ocup", {15'd0, ocupado}, 16'd1);
      repeat (8) @(negedge clk);
      check_eq("cont_fim", {15'd0, fim}, 16'd1);
      check_eq("cont_prod", produto, 16'd15);
      @(negedge clk);
      check_eq("cont_pronto", {15'd0, pronto}, 16'd1);
      check_eq("cont_hold", produto, 16'd15);
    end
    iniciar = 1'b0;
    @(negedge clk);

    // Reset in CALC cycle 5 discards the operation.
    a = 8'd100; b = 8'd100; iniciar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_ocup", {15'd0, ocupado}, 16'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_pronto", {15'd0, pronto}, 16'd1);
    check_eq("mid_ocupado", {15'd0, ocupado}, 16'd0);
    check_eq("mid_produto", produto, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    nfim = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fim) nfim++;
    end
    check_eq("mid_nofim", nfim[15:0], 16'd0);
    check_eq("mid_idle", {15'd0, pronto}, 16'd1);
    mul(8'd2, 8'd3, 16'd6, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
